fwuart_baudgen: RTL and testbench

//  Programmable fractional baud-tick generator; successor to the fixed-divider x16 generator.

---
 rtl/fwuart_pkg.sv | 25 ++
 rtl/fwuart_baudgen_if.sv | 28 ++
 rtl/fwuart_frac_div.sv | 55 +++++
 rtl/fwuart_baudgen.sv | 128 ++++++++++++
 tb/tb_fwuart_baudgen.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwuart_pkg.sv
// Shared constants and helpers for the fwuart baud generator: oversample
// mode encodings, phase wrap points and the reset divisor calculation.
package fwuart_pkg;

   localparam logic       OS_X8    = 1'b0;
   localparam logic       OS_X16   = 1'b1;
   localparam logic [3:0] OS8_MAX  = 4'd7;
   localparam logic [3:0] OS16_MAX = 4'd15;

   // round(clockrate * 2^frac_w / (baudrate * 16)) in fixed point int.frac
   function automatic logic [31:0] calc_rst_div(input int unsigned clockrate,
                                                input int unsigned baudrate,
                                                input int unsigned frac_w);
      logic [63:0] num;
      logic [63:0] den;
      num = 64'(clockrate) << frac_w;
      den = 64'(baudrate) * 64'd16;
      return 32'((num * 64'd2 + den) / (den * 64'd2));
   endfunction

   function automatic logic [3:0] phase_max(input logic os16);
      return (os16 == OS_X8) ? OS8_MAX : OS16_MAX;
   endfunction

endpackage

// File: rtl/fwuart_baudgen_if.sv
// Control/status bundle between the register block (master) and the
// baud generator (slave).
interface fwuart_baudgen_if #(
   parameter int DIV_W  = 32'sd16,
   parameter int FRAC_W = 32'sd4
);
   logic              enable;
   logic              resync;
   logic              cfg_load;
   logic [DIV_W-1:0]  cfg_div_int;
   logic [FRAC_W-1:0] cfg_div_frac;
   logic              cfg_os16;
   logic              tick_os;
   logic              tick_baud;
   logic [3:0]        os_phase;
   logic              cfg_pending;
   logic              cfg_err;

   modport master (
      output enable, resync, cfg_load, cfg_div_int, cfg_div_frac, cfg_os16,
      input  tick_os, tick_baud, os_phase, cfg_pending, cfg_err
   );

   modport slave (
      input  enable, resync, cfg_load, cfg_div_int, cfg_div_frac, cfg_os16,
      output tick_os, tick_baud, os_phase, cfg_pending, cfg_err
   );
endinterface

// File: rtl/fwuart_frac_div.sv
// Fractional clock divider: period is div_int, stretched by one clock after
// every accumulator carry, giving an average of div_int + div_frac/2^FRAC_W.
module fwuart_frac_div #(
   parameter int DIV_W  = 32'sd16,
   parameter int FRAC_W = 32'sd4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              run,
   input  logic              restart,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   output logic              tick
);

   logic [DIV_W-1:0]  cnt_r;
   logic [FRAC_W-1:0] acc_r;
   logic              carry_r;
   logic              tick_r;
   logic [DIV_W:0]    last_cnt_s;
   logic [DIV_W:0]    cnt_inc_s;
   logic [FRAC_W:0]   acc_sum_s;
   logic              wrap_s;

   assign last_cnt_s = {1'b0, div_int} + {{DIV_W{1'b0}}, carry_r} - {{DIV_W{1'b0}}, 1'b1};
   assign cnt_inc_s  = {1'b0, cnt_r} + {{DIV_W{1'b0}}, 1'b1};
   assign wrap_s     = ({1'b0, cnt_r} == last_cnt_s);
   assign acc_sum_s  = {1'b0, acc_r} + {1'b0, div_frac};
   assign tick       = tick_r;

   // Counter, accumulator and a tick register that is set one clock ahead so
   // it is high exactly while the counter sits at P-1.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r   <= {DIV_W{1'b0}};
         acc_r   <= {FRAC_W{1'b0}};
         carry_r <= 1'b0;
         tick_r  <= 1'b0;
      end else if (!run || restart) begin
         cnt_r   <= {DIV_W{1'b0}};
         acc_r   <= {FRAC_W{1'b0}};
         carry_r <= 1'b0;
         tick_r  <= 1'b0;
      end else if (wrap_s) begin
         cnt_r   <= {DIV_W{1'b0}};
         acc_r   <= acc_sum_s[FRAC_W-1:0];
         carry_r <= acc_sum_s[FRAC_W];
         tick_r  <= 1'b0;
      end else begin
         cnt_r   <= cnt_inc_s[DIV_W-1:0];
         tick_r  <= (cnt_inc_s == last_cnt_s);
      end
   end

endmodule

// File: rtl/fwuart_baudgen.sv
// Programmable fractional baud-tick generator: oversample and bit strobes,
// shadowed reconfiguration applied on bit boundaries, and phase resync.
module fwuart_baudgen
   import fwuart_pkg::*;
#(
   parameter int unsigned CLOCKRATE = 32'd50000000,
   parameter int unsigned BAUDRATE  = 32'd115200,
   parameter int          DIV_W     = 32'sd16,
   parameter int          FRAC_W    = 32'sd4
) (
   input logic             clock,
   input logic             reset_n,
   fwuart_baudgen_if.slave bus
);

   function automatic logic div_illegal(input logic [DIV_W-1:0] d);
      return (d[DIV_W-1:1] == {(DIV_W-1){1'b0}});
   endfunction

   localparam logic [31:0]       RST_DIV  = calc_rst_div(CLOCKRATE, BAUDRATE, $unsigned(FRAC_W));
   localparam logic [DIV_W-1:0]  RST_INT  = RST_DIV[FRAC_W +: DIV_W];
   localparam logic [FRAC_W-1:0] RST_FRAC = RST_DIV[FRAC_W-1:0];
   localparam logic              RST_ERR  = div_illegal(RST_INT);

   logic [DIV_W-1:0]  act_int_r;
   logic [FRAC_W-1:0] act_frac_r;
   logic              act_os16_r;
   logic [DIV_W-1:0]  sh_int_r;
   logic [FRAC_W-1:0] sh_frac_r;
   logic              sh_os16_r;
   logic              pending_r;
   logic              err_r;
   logic              en_d_r;
   logic [3:0]        phase_r;

   logic              run_s;
   logic              tick_s;
   logic              at_max_s;
   logic              baud_s;
   logic              imm_s;
   logic              shadow_wr_s;
   logic              def_apply_s;
   logic              restart_s;

   // Loads bypass the shadow whenever there is no running bit to protect.
   assign run_s       = bus.enable & ~err_r;
   assign at_max_s    = (phase_r == phase_max(act_os16_r));
   assign baud_s      = tick_s & at_max_s;
   assign imm_s       = bus.cfg_load & (~bus.enable | bus.resync | err_r);
   assign shadow_wr_s = bus.cfg_load & ~imm_s;
   assign def_apply_s = pending_r & baud_s & ~bus.cfg_load;
   assign restart_s   = bus.resync | imm_s | def_apply_s | (bus.enable & ~en_d_r);

   fwuart_frac_div #(
      .DIV_W  (DIV_W),
      .FRAC_W (FRAC_W)
   ) u_div (
      .clock    (clock),
      .reset_n  (reset_n),
      .run      (run_s),
      .restart  (restart_s),
      .div_int  (act_int_r),
      .div_frac (act_frac_r),
      .tick     (tick_s)
   );

   // Active/shadow configuration, pending flag and divisor legality.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         act_int_r  <= RST_INT;
         act_frac_r <= RST_FRAC;
         act_os16_r <= OS_X16;
         sh_int_r   <= RST_INT;
         sh_frac_r  <= RST_FRAC;
         sh_os16_r  <= OS_X16;
         pending_r  <= 1'b0;
         err_r      <= RST_ERR;
      end else if (imm_s) begin
         act_int_r  <= bus.cfg_div_int;
         act_frac_r <= bus.cfg_div_frac;
         act_os16_r <= bus.cfg_os16;
         pending_r  <= 1'b0;
         err_r      <= div_illegal(bus.cfg_div_int);
      end else if (shadow_wr_s) begin
         sh_int_r   <= bus.cfg_div_int;
         sh_frac_r  <= bus.cfg_div_frac;
         sh_os16_r  <= bus.cfg_os16;
         pending_r  <= 1'b1;
      end else if (def_apply_s) begin
         act_int_r  <= sh_int_r;
         act_frac_r <= sh_frac_r;
         act_os16_r <= sh_os16_r;
         pending_r  <= 1'b0;
         err_r      <= div_illegal(sh_int_r);
      end else begin
         pending_r  <= pending_r;
      end
   end

   // Enable history, used to restart the period on a rising enable.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         en_d_r <= 1'b0;
      end else begin
         en_d_r <= bus.enable;
      end
   end

   // Oversample phase within the current bit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase_r <= 4'd0;
      end else if (!run_s || restart_s) begin
         phase_r <= 4'd0;
      end else if (tick_s) begin
         phase_r <= at_max_s ? 4'd0 : (phase_r + 4'd1);
      end else begin
         phase_r <= phase_r;
      end
   end

   assign bus.tick_os     = tick_s;
   assign bus.tick_baud   = baud_s;
   assign bus.os_phase    = phase_r;
   assign bus.cfg_pending = pending_r;
   assign bus.cfg_err     = err_r;

endmodule

// File: tb/tb_fwuart_baudgen.sv
// Bench for fwuart_baudgen: expected tick timestamps are queued when stimulus
// starts a run and matched against every observed tick_os.
module tb_fwuart_baudgen;

   typedef struct {
      int cyc;
      int phase;
      bit baud;
   } exp_t;

   typedef struct {
      int di;
      int df;
      bit os16;
      int exp_span16;
      int exp_baud;
   } vec_t;

   logic clock;
   logic reset_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   int   tick_log[$];
   int   baud_log[$];
   vec_t vecs[6];

   fwuart_baudgen_if #(.DIV_W(16), .FRAC_W(4)) bus ();

   fwuart_baudgen #(
      .CLOCKRATE (50000000),
      .BAUDRATE  (115200),
      .DIV_W     (16),
      .FRAC_W    (4)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic go_to(input int target);
      while (cyc < target) step();
   endtask

   // Expected ticks of a run whose period restarts at cycle 'start'.
   task automatic push_run(input int start, input int di, input int df, input bit os16, input int n);
      int t = start;
      int acc = 0;
      int carry = 0;
      int modv = os16 ? 16 : 8;
      for (int i = 0; i < n; i++) begin
         exp_t e;
         t = t + di + carry;
         e.cyc = t;
         e.phase = i % modv;
         e.baud = ((i % modv) == (modv - 1));
         sb.push_back(e);
         acc = acc + df;
         carry = (acc >= 16) ? 1 : 0;
         acc = acc % 16;
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         step();
         n++;
      end
      if (sb.size() != 0) begin
         check("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic stop_run();
      bus.enable = 1'b0;
      step();
      step();
      check("idle_phase", int'(bus.os_phase), 0);
   endtask

   task automatic load_idle(input int di, input int df, input bit os16);
      bus.cfg_div_int = 16'(di);
      bus.cfg_div_frac = 4'(df);
      bus.cfg_os16 = os16;
      bus.cfg_load = 1'b1;
      step();
      bus.cfg_load = 1'b0;
      step();
      check("idle_load_pending", int'(bus.cfg_pending), 0);
   endtask

   always @(negedge clock) begin
      if (reset_n && bus.tick_os) begin
         tick_log.push_back(cyc);
         if (bus.tick_baud) baud_log.push_back(cyc);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_tick: tick_os at cycle %0d, required none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("tick_cycle", cyc, e.cyc);
            check("tick_phase", int'(bus.os_phase), e.phase);
            check("tick_baud", int'(bus.tick_baud), int'(e.baud));
         end
      end else if (reset_n && bus.tick_baud) begin
         checks++;
         errors++;
         $display("FAIL baud_without_os: tick_baud=1 tick_os=0 at cycle %0d", cyc);
      end
   end

   initial begin
      int k;
      int span;
      int bint;

      vecs[0] = '{di: 3,  df: 0, os16: 1'b1, exp_span16: 48,  exp_baud: 48};
      vecs[1] = '{di: 3,  df: 8, os16: 1'b1, exp_span16: 56,  exp_baud: 56};
      vecs[2] = '{di: 3,  df: 8, os16: 1'b0, exp_span16: 56,  exp_baud: 28};
      vecs[3] = '{di: 5,  df: 0, os16: 1'b0, exp_span16: 80,  exp_baud: 40};
      vecs[4] = '{di: 4,  df: 4, os16: 1'b0, exp_span16: 68,  exp_baud: 34};
      vecs[5] = '{di: 27, df: 2, os16: 1'b1, exp_span16: 434, exp_baud: 434};

      reset_n = 1'b0;
      bus.enable = 1'b0;
      bus.resync = 1'b0;
      bus.cfg_load = 1'b0;
      bus.cfg_div_int = 16'd0;
      bus.cfg_div_frac = 4'd0;
      bus.cfg_os16 = 1'b0;
      repeat (3) step();
      check("rst_tick_os", int'(bus.tick_os), 0);
      check("rst_tick_baud", int'(bus.tick_baud), 0);
      check("rst_os_phase", int'(bus.os_phase), 0);
      check("rst_cfg_pending", int'(bus.cfg_pending), 0);
      check("rst_cfg_err", int'(bus.cfg_err), 0);
      reset_n = 1'b1;
      step();
      check("post_rst_cfg_err", int'(bus.cfg_err), 0);
      check("post_rst_tick_os", int'(bus.tick_os), 0);

      // Table: steady-state tick spacing for several divisors and modes.
      for (int v = 0; v < 6; v++) begin
         load_idle(vecs[v].di, vecs[v].df, vecs[v].os16);
         tick_log.delete();
         baud_log.delete();
         k = cyc;
         bus.enable = 1'b1;
         push_run(k, vecs[v].di, vecs[v].df, vecs[v].os16, 40);
         drain(3000);
         stop_run();
         span = (tick_log.size() > 17) ? (tick_log[17] - tick_log[1]) : -1;
         check("span16", span, vecs[v].exp_span16);
         bint = (baud_log.size() > 1) ? (baud_log[1] - baud_log[0]) : -1;
         check("baud_interval", bint, vecs[v].exp_baud);
      end

      // Resync with the counter at 1 in the middle of a bit.
      load_idle(3, 0, 1'b1);
      k = cyc;
      bus.enable = 1'b1;
      push_run(k, 3, 0, 1'b1, 5);
      drain(200);
      step();
      bus.resync = 1'b1;
      push_run(cyc, 3, 0, 1'b1, 20);
      step();
      bus.resync = 1'b0;
      drain(200);
      stop_run();

      // Reconfiguration while running waits for the bit boundary.
      load_idle(3, 0, 1'b0);
      k = cyc;
      bus.enable = 1'b1;
      push_run(k, 3, 0, 1'b0, 8);
      push_run(k + 24, 5, 0, 1'b0, 10);
      go_to(k + 5);
      bus.cfg_div_int = 16'd5;
      bus.cfg_div_frac = 4'd0;
      bus.cfg_os16 = 1'b0;
      bus.cfg_load = 1'b1;
      step();
      bus.cfg_load = 1'b0;
      check("pending_after_load", int'(bus.cfg_pending), 1);
      go_to(k + 24);
      check("pending_at_baud", int'(bus.cfg_pending), 1);
      step();
      check("pending_after_apply", int'(bus.cfg_pending), 0);
      drain(300);
      stop_run();

      // Illegal divisor parks the generator; a legal reload revives it.
      load_idle(1, 0, 1'b1);
      check("err_set", int'(bus.cfg_err), 1);
      bus.enable = 1'b1;
      repeat (30) step();
      check("err_hold", int'(bus.cfg_err), 1);
      check("err_phase", int'(bus.os_phase), 0);
      k = cyc;
      bus.cfg_div_int = 16'd4;
      bus.cfg_load = 1'b1;
      push_run(k, 4, 0, 1'b1, 20);
      step();
      bus.cfg_load = 1'b0;
      check("err_cleared", int'(bus.cfg_err), 0);
      check("err_no_pending", int'(bus.cfg_pending), 0);
      drain(300);
      stop_run();

      // Async reset mid-bit with a load still pending.
      load_idle(3, 0, 1'b1);
      k = cyc;
      bus.enable = 1'b1;
      push_run(k, 3, 0, 1'b1, 4);
      drain(200);
      bus.cfg_div_int = 16'd6;
      bus.cfg_load = 1'b1;
      step();
      bus.cfg_load = 1'b0;
      check("pending_before_reset", int'(bus.cfg_pending), 1);
      #3;
      reset_n = 1'b0;
      #1;
      check("midrst_tick_os", int'(bus.tick_os), 0);
      check("midrst_os_phase", int'(bus.os_phase), 0);
      check("midrst_pending", int'(bus.cfg_pending), 0);
      check("midrst_cfg_err", int'(bus.cfg_err), 0);
      @(posedge clock);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      push_run(cyc, 27, 2, 1'b1, 20);
      drain(1000);
      check("post_reset_pending", int'(bus.cfg_pending), 0);
      stop_run();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
